// File: rtl/sram_frame_pkg.sv
// Shared types and helpers for the SRAM frame reader: FSM encoding, pixel record
// and the 8-to-10 bit channel expansion used by the unpacker.
package sram_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       sof;
        logic       eol;
    } pixel_t;

    localparam int WORDS_PER_PAIR = 3;
    localparam int PIX_W          = 30;

    // Replicating the top bits keeps full-scale 8-bit values at full-scale 10-bit.
    function automatic logic [9:0] expand8to10(input logic [7:0] b);
        return {b, b[7:6]};
    endfunction

endpackage

// File: rtl/sram_frame_reader_fifo.sv
// First-word-fall-through pixel FIFO: the head entry is always visible on data_o,
// pop consumes it. Flush empties the FIFO synchronously.
module pixel_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 30
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/sram_frame_reader.sv
// Reads one packed RGB888 frame (2 pixels per 3 words) from SRAM and streams it
// as 30-bit pixels. Handshake: a pixel transfers on any cycle with o_valid && i_ready.
module sram_frame_reader
    import sram_frame_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 20
) (
    input  logic              i_vga_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_WE_N,
    output logic [9:0]        o_red,
    output logic [9:0]        o_green,
    output logic [9:0]        o_blue,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_sof,
    output logic              o_eol
);
    localparam int TOTAL_WORDS = H_ACTIVE * V_ACTIVE * WORDS_PER_PAIR / 2;
    localparam int WC_W  = $clog2(TOTAL_WORDS);
    localparam int X_W   = $clog2(H_ACTIVE);
    localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic [15:0]       hold_rg_q, hold_rg_d;
    logic [7:0]        hold_r1_q, hold_r1_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              last_popped_q, last_popped_d;

    logic              issue, busy, done;
    logic              start_acc, last_word, inflight, room, push, pop;
    logic [CNT_W:0]    need;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full;
    logic [PIX_W-1:0]  push_data, fifo_dout;
    logic [15:0]       dq_in;
    pixel_t            head;

    assign SRAM_DQ   = 16'bz;
    assign dq_in     = SRAM_DQ;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_WE_N = 1'b1;
    assign SRAM_ADDR = addr_q;

    assign start_acc = i_start && (state_q == ST_IDLE);
    assign last_word = (word_cnt_q == WC_W'(TOTAL_WORDS - 1));
    // Word issued now lands this edge; phase 1/2 words each produce a pixel.
    assign inflight  = (phase_q != 2'd0);
    assign need      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
    assign room      = (need <= (CNT_W+1)'(FIFO_DEPTH - 1));
    assign push      = issue && inflight && !i_abort;
    assign pop       = o_valid && i_ready;

    always_ff @(posedge i_vga_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (i_start) state_d = ST_FETCH;
                ST_FETCH: if (issue && last_word) state_d = ST_DRAIN;
                ST_DRAIN: if (done) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        issue = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                busy  = 1'b1;
                issue = room && !fifo_full;
            end
            ST_DRAIN: begin
                busy = !last_popped_q;
                done = last_popped_q && fifo_empty;
            end
            default: ;
        endcase
    end

    assign o_busy = busy;
    assign o_done = done;

    always_comb begin
        push_data = '0;
        if (phase_q == 2'd1)
            push_data = {expand8to10(hold_rg_q[15:8]), expand8to10(hold_rg_q[7:0]),
                         expand8to10(dq_in[15:8])};
        else if (phase_q == 2'd2)
            push_data = {expand8to10(hold_r1_q), expand8to10(dq_in[15:8]),
                         expand8to10(dq_in[7:0])};
    end

    always_comb begin
        addr_d        = addr_q;
        word_cnt_d    = word_cnt_q;
        phase_d       = phase_q;
        hold_rg_d     = hold_rg_q;
        hold_r1_d     = hold_r1_q;
        x_d           = x_q;
        y_d           = y_q;
        last_popped_d = last_popped_q;
        if (i_abort) begin
            word_cnt_d    = '0;
            phase_d       = 2'd0;
            x_d           = '0;
            y_d           = '0;
            last_popped_d = 1'b0;
        end else begin
            if (start_acc) begin
                addr_d        = i_base_addr;
                word_cnt_d    = '0;
                phase_d       = 2'd0;
                x_d           = '0;
                y_d           = '0;
                last_popped_d = 1'b0;
            end
            if (issue) begin
                if (phase_q == 2'd0) hold_rg_d = dq_in;
                if (phase_q == 2'd1) hold_r1_d = dq_in[7:0];
                phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
                // Address stays on the final word so it remains observable after the frame.
                if (!last_word) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    word_cnt_d = word_cnt_q + WC_W'(1);
                end
            end
            if (pop) begin
                if (x_q == X_W'(H_ACTIVE - 1)) begin
                    x_d = '0;
                    if (y_q == Y_W'(V_ACTIVE - 1)) begin
                        y_d           = '0;
                        last_popped_d = 1'b1;
                    end else begin
                        y_d = y_q + Y_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            if (done) last_popped_d = 1'b0;
        end
    end

    always_ff @(posedge i_vga_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q        <= '0;
            word_cnt_q    <= '0;
            phase_q       <= 2'd0;
            hold_rg_q     <= '0;
            hold_r1_q     <= '0;
            x_q           <= '0;
            y_q           <= '0;
            last_popped_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            word_cnt_q    <= word_cnt_d;
            phase_q       <= phase_d;
            hold_rg_q     <= hold_rg_d;
            hold_r1_q     <= hold_r1_d;
            x_q           <= x_d;
            y_q           <= y_d;
            last_popped_q <= last_popped_d;
        end
    end

    pixel_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk_i   (i_vga_clk),
        .rst_i   (i_rst),
        .flush_i (i_abort),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_comb begin
        head     = '0;
        head.r   = fifo_dout[29:20];
        head.g   = fifo_dout[19:10];
        head.b   = fifo_dout[9:0];
        head.sof = (x_q == '0) && (y_q == '0);
        head.eol = (x_q == X_W'(H_ACTIVE - 1));
    end

    assign o_valid = !fifo_empty;
    assign o_red   = o_valid ? head.r : '0;
    assign o_green = o_valid ? head.g : '0;
    assign o_blue  = o_valid ? head.b : '0;
    assign o_sof   = o_valid && head.sof;
    assign o_eol   = o_valid && head.eol;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader on a reduced 8x4 frame with a small SRAM model.
module tb_sram_frame_reader;
    localparam int H      = 8;
    localparam int V      = 4;
    localparam int FD     = 4;
    localparam int AW     = 20;
    localparam int NPIX   = H * V;
    localparam int NWORDS = NPIX * 3 / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic [AW-1:0] base = '0;

    logic          o_busy, o_done, o_valid, o_sof, o_eol;
    logic [AW-1:0] sram_addr;
    wire  [15:0]   sram_dq;
    logic          ce_n, oe_n, lb_n, ub_n, we_n;
    logic [9:0]    o_red, o_green, o_blue;

    logic [15:0]   mem [256];
    assign sram_dq = mem[sram_addr[7:0]];

    sram_frame_reader #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(FD), .ADDR_W(AW)
    ) dut (
        .i_vga_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_base_addr(base), .o_busy(o_busy), .o_done(o_done),
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
        .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n),
        .SRAM_WE_N(we_n), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_valid(o_valid), .i_ready(ready), .o_sof(o_sof), .o_eol(o_eol)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          pop_cnt = 0;
    int          eol_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          ready_auto = 1'b0;
    bit          rand_mode = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_pix = '0;

    typedef struct {
        logic [15:0] w0, w1, w2;
        logic [9:0]  r0, g0, b0, r1, g1, b1;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [9:0] exp10(input logic [7:0] b);
        return {b, b[7:6]};
    endfunction

    always @(posedge clk) begin
        #2;
        if (ready_auto) ready = rand_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // Scoreboard / monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [31:0] cur;
        cur = {o_red, o_green, o_blue, o_sof, o_eol};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("sram_ctl", {27'd0, we_n, ce_n, oe_n, lb_n, ub_n}, 32'h10);
            check("fifo_count_max", {31'd0, dut.u_fifo.count_o <= 3'(FD)}, 32'd1);
            if (prev_stall) check("stall_hold", {o_valid, cur[31:1]}, {1'b1, prev_pix[31:1]});
            if (o_done) done_cnt++;
            if (o_valid && ready) begin
                pop_cnt++;
                if (o_eol) eol_cnt++;
                got_q.push_back(cur);
                if (exp_q.size() == 0) check("pop_unexpected", cur, 32'hFFFF_FFFF);
                else check("pixel", cur, exp_q.pop_front());
            end
            prev_stall = o_valid && !ready && !abort;
            prev_pix   = cur;
        end
    end

    task automatic build_exp(input logic [AW-1:0] b);
        exp_q.delete();
        for (int k = 0; k < NPIX; k++) begin
            logic [AW-1:0] a0, a1, a2;
            logic [15:0]   w0, w1, w2;
            logic [7:0]    r, g, bl;
            a0 = b + AW'(3 * (k / 2));
            a1 = a0 + AW'(1);
            a2 = a0 + AW'(2);
            w0 = mem[a0[7:0]];
            w1 = mem[a1[7:0]];
            w2 = mem[a2[7:0]];
            if (k % 2 == 0) begin r = w0[15:8]; g = w0[7:0]; bl = w1[15:8]; end
            else begin r = w1[7:0]; g = w2[15:8]; bl = w2[7:0]; end
            exp_q.push_back({exp10(r), exp10(g), exp10(bl), k == 0, (k % H) == H - 1});
        end
    endtask

    task automatic start_pulse(input logic [AW-1:0] b);
        @(posedge clk); #1 start = 1'b1; base = b;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    endtask

    task automatic run_frame(input logic [AW-1:0] b, input bit rmode);
        int lat;
        int t;
        logic [AW-1:0] ea;
        build_exp(b);
        got_q.delete();
        pop_cnt = 0; eol_cnt = 0; done_cnt = 0;
        rand_mode = rmode; ready_auto = 1'b1;
        start_pulse(b);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat <= 3) begin
                ea = b + AW'(lat - 1);
                check($sformatf("addr_cycle%0d", lat), {12'd0, sram_addr}, {12'd0, ea});
            end
        end while (!o_valid && lat < 20);
        check("first_valid_latency", lat, 3);
        if (rmode) begin
            @(posedge clk); #1 start = 1'b1; base = 20'h00080;
            @(posedge clk); #1 start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 2000) begin @(negedge clk); t++; end
        check("done_timeout", {31'd0, t < 2000}, 32'd1);
        repeat (3) @(negedge clk);
        ea = b + AW'(NWORDS - 1);
        check("pop_count", pop_cnt, NPIX);
        check("eol_count", eol_cnt, V);
        check("done_count", done_cnt, 1);
        check("exp_left", exp_q.size(), 0);
        check("last_addr", {12'd0, sram_addr}, {12'd0, ea});
        check("busy_idle", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        int t;
        vecs[0] = '{16'h1122, 16'h3344, 16'h5566, 10'h044, 10'h088, 10'h0CC, 10'h111, 10'h155, 10'h199};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        vecs[3] = '{16'h80C0, 16'h4001, 16'h7FFE, 10'h202, 10'h303, 10'h101, 10'h004, 10'h1FD, 10'h3FB};
        fill_mem();

        repeat (3) @(negedge clk);
        check("rst_busy_done_valid", {29'd0, o_busy, o_done, o_valid}, 32'd0);
        check("rst_addr", {12'd0, sram_addr}, 32'd0);
        check("rst_rgb", {2'd0, o_red, o_green, o_blue}, 32'd0);
        check("rst_sof_eol", {30'd0, o_sof, o_eol}, 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            fill_mem();
            mem[0] = vecs[v].w0; mem[1] = vecs[v].w1; mem[2] = vecs[v].w2;
            run_frame(20'h00000, 1'b0);
            if (got_q.size() >= 2) begin
                check($sformatf("vec%0d_pix0", v), got_q[0],
                      {vecs[v].r0, vecs[v].g0, vecs[v].b0, 1'b1, 1'b0});
                check($sformatf("vec%0d_pix1", v), got_q[1],
                      {vecs[v].r1, vecs[v].g1, vecs[v].b1, 1'b0, 1'b0});
            end else begin
                check($sformatf("vec%0d_pixcount", v), got_q.size(), 2);
            end
        end

        run_frame(20'h00000, 1'b1);

        fill_mem();
        run_frame(20'hFFFFE, 1'b0);

        build_exp(20'h00000);
        pop_cnt = 0; done_cnt = 0; rand_mode = 1'b0; ready_auto = 1'b1;
        start_pulse(20'h00000);
        t = 0;
        while (pop_cnt < 10 && t < 200) begin @(posedge clk); t++; end
        check("abort_reach", {31'd0, pop_cnt >= 10}, 32'd1);
        #1 ready_auto = 1'b0; ready = 1'b0; abort = 1'b1; start = 1'b1; base = 20'h00040;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, o_valid}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        exp_q.delete();
        run_frame(20'h00000, 1'b0);
        if (got_q.size() > 0) check("after_abort_sof", {31'd0, got_q[0][1]}, 32'd1);

        build_exp(20'h00000);
        rand_mode = 1'b0; ready_auto = 1'b1;
        start_pulse(20'h00000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy_done_valid", {29'd0, o_busy, o_done, o_valid}, 32'd0);
        check("midrst_addr", {12'd0, sram_addr}, 32'd0);
        check("midrst_rgb", {2'd0, o_red, o_green, o_blue}, 32'd0);
        check("midrst_sof_eol_we", {29'd0, o_sof, o_eol, we_n}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        run_frame(20'h00000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
